// File: rtl/mastermind_pkg.sv
// Shared types and default sizing for the Mastermind guess path.
package mastermind_pkg;

    localparam int NUM_DIGITS   = 4;
    localparam int DIGIT_W      = 3;
    localparam int NUM_COLORS   = 6;
    localparam int MAX_ATTEMPTS = 10;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        SUBMIT,
        OVER
    } state_e;

    typedef logic [NUM_DIGITS*DIGIT_W-1:0] guess_t;

endpackage

// File: rtl/guess_digit_bank.sv
// Indexed digit register file; write, clear-one and clear-all.
import mastermind_pkg::*;

module guess_digit_bank #(
    parameter int NUM_DIGITS = mastermind_pkg::NUM_DIGITS,
    parameter int DIGIT_W    = mastermind_pkg::DIGIT_W,
    parameter int IDX_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en_i,
    input  logic                          clr_one_i,
    input  logic                          clr_all_i,
    input  logic [IDX_W-1:0]              idx_i,
    input  logic [DIGIT_W-1:0]            data_i,
    output logic [NUM_DIGITS*DIGIT_W-1:0] guess_o
);

    logic [DIGIT_W-1:0] dig_q [NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (reset || clr_all_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            dig_q[idx_i] <= data_i;
        end else if (clr_one_i) begin
            dig_q[idx_i] <= '0;
        end
    end

    always_comb begin
        guess_o = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            guess_o[i*DIGIT_W +: DIGIT_W] = dig_q[i];
        end
    end

endmodule

// File: rtl/guess_entry.sv
// Guess collection FSM and attempt counter for the Mastermind machine.
// Define GUESS_BACKSPACE_EN to enable digit deletion with del_pulse.
import mastermind_pkg::*;

module guess_entry #(
    parameter int NUM_DIGITS   = mastermind_pkg::NUM_DIGITS,
    parameter int DIGIT_W      = mastermind_pkg::DIGIT_W,
    parameter int NUM_COLORS   = mastermind_pkg::NUM_COLORS,
    parameter int MAX_ATTEMPTS = mastermind_pkg::MAX_ATTEMPTS,
    parameter int CNT_W        = mastermind_pkg::CNT_W,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clearall,
    input  logic                          restartgame,
    input  logic                          enter_pulse,
    input  logic [DIGIT_W-1:0]            sw_digit,
    input  logic                          del_pulse,
    input  logic                          guess_ready,
    input  logic                          win,
    output logic                          guess_valid,
    output logic [NUM_DIGITS*DIGIT_W-1:0] guess_out,
    output logic [IDX_W-1:0]              digit_idx,
    output logic [CNT_W-1:0]              attempt_cnt,
    output logic                          digit_err,
    output logic                          game_over,
    output logic                          game_won
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ATTEMPTS);
    localparam logic [DIGIT_W:0] NCOL     = (DIGIT_W+1)'(NUM_COLORS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               valid_q;
    logic               err_q, err_d;
    logic               over_q, over_d;
    logic               won_q, won_d;
    logic               wr_en, clr_one, clr_all;
    logic [IDX_W-1:0]   bank_idx;
    logic               digit_ok;

    assign digit_ok = ({1'b0, sw_digit} < NCOL);
    assign cnt_inc  = cnt_q + 1'b1;

`ifdef GUESS_BACKSPACE_EN
`else
    logic unused_del;
    assign unused_del = del_pulse;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        over_d   = over_q;
        won_d    = won_q;
        wr_en    = 1'b0;
        clr_one  = 1'b0;
        clr_all  = 1'b0;
        bank_idx = idx_q;
        if (clearall || restartgame) begin
            state_d = restartgame ? ENTRY : IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            over_d  = 1'b0;
            won_d   = 1'b0;
            clr_all = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ENTRY: begin
                    if (enter_pulse) begin
                        if (digit_ok) begin
                            wr_en = 1'b1;
                            if (idx_q == LAST_IDX) begin
                                idx_d   = '0;
                                state_d = SUBMIT;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`ifdef GUESS_BACKSPACE_EN
                    else if (del_pulse && (idx_q != '0)) begin
                        idx_d    = idx_q - 1'b1;
                        bank_idx = idx_q - 1'b1;
                        clr_one  = 1'b1;
                    end
`endif
                end
                SUBMIT: begin
                    if (guess_ready) begin
                        cnt_d = cnt_inc;
                        if (win) begin
                            state_d = OVER;
                            over_d  = 1'b1;
                            won_d   = 1'b1;
                        end else if (cnt_inc == MAX_CNT) begin
                            state_d = OVER;
                            over_d  = 1'b1;
                            won_d   = 1'b0;
                        end else begin
                            state_d = ENTRY;
                            clr_all = 1'b1;
                        end
                    end
                end
                OVER: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            over_q  <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == SUBMIT);
            err_q   <= err_d;
            over_q  <= over_d;
            won_q   <= won_d;
        end
    end

    guess_digit_bank #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .clr_one_i (clr_one),
        .clr_all_i (clr_all),
        .idx_i     (bank_idx),
        .data_i    (sw_digit),
        .guess_o   (guess_out)
    );

    assign guess_valid = valid_q;
    assign digit_idx   = idx_q;
    assign attempt_cnt = cnt_q;
    assign digit_err   = err_q;
    assign game_over   = over_q;
    assign game_won    = won_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed self-checking bench for guess_entry.
module tb_guess_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic        clearall;
    logic        restartgame;
    logic        enter_pulse;
    logic [2:0]  sw_digit;
    logic        del_pulse;
    logic        guess_ready;
    logic        win;
    logic        guess_valid;
    logic [11:0] guess_out;
    logic [1:0]  digit_idx;
    logic [3:0]  attempt_cnt;
    logic        digit_err;
    logic        game_over;
    logic        game_won;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    guess_entry dut (
        .clk         (clk),
        .reset       (reset),
        .clearall    (clearall),
        .restartgame (restartgame),
        .enter_pulse (enter_pulse),
        .sw_digit    (sw_digit),
        .del_pulse   (del_pulse),
        .guess_ready (guess_ready),
        .win         (win),
        .guess_valid (guess_valid),
        .guess_out   (guess_out),
        .digit_idx   (digit_idx),
        .attempt_cnt (attempt_cnt),
        .digit_err   (digit_err),
        .game_over   (game_over),
        .game_won    (game_won)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [2:0] d);
        sw_digit    = d;
        enter_pulse = 1'b1;
        tick();
        enter_pulse = 1'b0;
    endtask

    task automatic pulse_clr(input logic ca, input logic rg);
        clearall    = ca;
        restartgame = rg;
        tick();
        clearall    = 1'b0;
        restartgame = 1'b0;
    endtask

    task automatic hshake(input logic w);
        guess_ready = 1'b1;
        win         = w;
        tick();
        guess_ready = 1'b0;
        win         = 1'b0;
    endtask

    task automatic full_guess();
        enter(3'd1);
        enter(3'd2);
        enter(3'd3);
        enter(3'd4);
    endtask

    initial begin
        reset = 1'b1; clearall = 1'b0; restartgame = 1'b0;
        enter_pulse = 1'b0; sw_digit = '0; del_pulse = 1'b0;
        guess_ready = 1'b0; win = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 32'(guess_valid), 32'd0);
        chk("rst_guess", 32'(guess_out), 32'd0);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        chk("rst_cnt", 32'(attempt_cnt), 32'd0);
        chk("rst_flags", {29'd0, digit_err, game_over, game_won}, 32'd0);

        enter(3'd1);
        chk("idle_ignore_idx", 32'(digit_idx), 32'd0);
        chk("idle_ignore_guess", 32'(guess_out), 32'd0);

        pulse_clr(1'b0, 1'b1);
        enter(3'd1);
        enter(3'd2);
        chk("entry_idx2", 32'(digit_idx), 32'd2);
        enter(3'd6);
        chk("err6_pulse", 32'(digit_err), 32'd1);
        chk("err6_idx", 32'(digit_idx), 32'd2);
        tick();
        chk("err6_clear", 32'(digit_err), 32'd0);
        enter(3'd7);
        chk("err7_pulse", 32'(digit_err), 32'd1);
        chk("err7_guess", 32'(guess_out), 32'o0021);
        tick();
        chk("err7_clear", 32'(digit_err), 32'd0);
        chk("err7_idx", 32'(digit_idx), 32'd2);

        enter(3'd3);
        chk("pre_submit_valid", 32'(guess_valid), 32'd0);
        enter(3'd4);
        chk("submit_valid", 32'(guess_valid), 32'd1);
        chk("submit_guess", 32'(guess_out), 32'o4321);
        chk("submit_idx", 32'(digit_idx), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) enter(3'd5);
            else tick();
            chk("hold_guess", 32'(guess_out), 32'o4321);
            chk("hold_valid", 32'(guess_valid), 32'd1);
        end

        hshake(1'b0);
        chk("hs1_cnt", 32'(attempt_cnt), 32'd1);
        chk("hs1_valid", 32'(guess_valid), 32'd0);
        chk("hs1_guess", 32'(guess_out), 32'd0);
        chk("hs1_over", 32'(game_over), 32'd0);
        for (int g = 2; g <= 10; g++) begin
            full_guess();
            hshake(1'b0);
        end
        chk("lose_cnt", 32'(attempt_cnt), 32'd10);
        chk("lose_over", 32'(game_over), 32'd1);
        chk("lose_won", 32'(game_won), 32'd0);
        chk("lose_valid", 32'(guess_valid), 32'd0);
        enter(3'd2);
        chk("over_ignore_idx", 32'(digit_idx), 32'd0);
        chk("over_hold_guess", 32'(guess_out), 32'o4321);
        chk("over_hold_cnt", 32'(attempt_cnt), 32'd10);

        pulse_clr(1'b0, 1'b1);
        chk("restart_cnt", 32'(attempt_cnt), 32'd0);
        chk("restart_over", 32'(game_over), 32'd0);
        full_guess();
        hshake(1'b0);
        full_guess();
        hshake(1'b0);
        full_guess();
        hshake(1'b1);
        chk("win_cnt", 32'(attempt_cnt), 32'd3);
        chk("win_over", 32'(game_over), 32'd1);
        chk("win_won", 32'(game_won), 32'd1);
        pulse_clr(1'b0, 1'b1);
        chk("win_restart_cnt", 32'(attempt_cnt), 32'd0);
        chk("win_restart_won", 32'(game_won), 32'd0);
        enter(3'd5);
        chk("win_restart_entry", 32'(digit_idx), 32'd1);

        enter(3'd0);
        enter(3'd1);
        enter(3'd2);
        chk("abort_pre_valid", 32'(guess_valid), 32'd1);
        pulse_clr(1'b1, 1'b0);
        chk("abort_valid", 32'(guess_valid), 32'd0);
        chk("abort_guess", 32'(guess_out), 32'd0);
        enter(3'd3);
        chk("abort_idle", 32'(digit_idx), 32'd0);
        pulse_clr(1'b1, 1'b1);
        enter(3'd3);
        chk("both_entry", 32'(digit_idx), 32'd1);

        pulse_clr(1'b0, 1'b1);
        del_pulse = 1'b1; tick(); del_pulse = 1'b0;
        chk("del_at0_idx", 32'(digit_idx), 32'd0);
        chk("del_at0_guess", 32'(guess_out), 32'd0);
        enter(3'd5);
        enter(3'd2);
        del_pulse = 1'b1; tick(); del_pulse = 1'b0;
`ifdef GUESS_BACKSPACE_EN
        chk("del_idx", 32'(digit_idx), 32'd1);
        chk("del_guess", 32'(guess_out), 32'o0005);
        enter(3'd3);
        chk("bs_idx", 32'(digit_idx), 32'd2);
        chk("bs_guess", 32'(guess_out), 32'o0035);
`else
        chk("nodel_idx", 32'(digit_idx), 32'd2);
        chk("nodel_guess", 32'(guess_out), 32'o0025);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
